ram_playback_reader: RTL
========================

Name: ram_playback_reader

Overview:
- Reader end of the true dual-port RAM. Drives one read port (address out, write-enable held low) and turns the RAM's fixed 1-cycle read latency into a valid/ready sample stream with backpressure.
- Used in the synthetic FRB generator: the host writes a pulse waveform through the other RAM port, and this block plays it back for a programmed length and loop count toward the DAC path.

Parameters:
- DATA_WIDTH, 8, sample width; must match the RAM.
- ADDR_WIDTH, 5, RAM address width; the RAM depth is 2**ADDR_WIDTH.
- LOOP_WIDTH, 16, width of the loop counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  one-cycle pulse; begins playback; ignored while busy.
- stop  in  1  one-cycle pulse; ends playback early; ignored while idle.
- length  in  ADDR_WIDTH+1  samples per pass, valid range 0..2**ADDR_WIDTH; latched on start.
- n_loops  in  LOOP_WIDTH  number of passes; 0 means play until stop; latched on start.
- ram_addr  out  ADDR_WIDTH  read address to the RAM port.
- ram_we  out  1  tied to 0.
- ram_dout  in  DATA_WIDTH  RAM read data; valid 1 cycle after its address is presented.
- m_data  out  DATA_WIDTH  output sample.
- m_valid  out  1  output sample valid.
- m_ready  in  1  downstream ready.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when playback finishes.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FSM goes to IDLE; address, loop and buffer state clear.
  - m_valid=0, busy=0, done=0, ram_addr=0.
  - Reset applied mid-playback discards all buffered and in-flight samples; none of them appear after reset.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start when length != 0.
  - IDLE -> IDLE on start when length == 0; done pulses in the next cycle and busy stays 0.
  - RUN -> DRAIN after the last address of the last pass is issued, or on stop.
  - DRAIN -> IDLE once no read is in flight and the buffer is empty; done=1 in the first IDLE cycle.
- Read issue rule:
  - A read issues in a RUN cycle only if (buffer_count + in_flight) < 2.
  - The buffer holds 2 entries; in_flight is 1 when a read was issued in the previous cycle.
  - ram_addr holds its value in cycles where no read issues. The RAM re-reads the same address harmlessly; the block ignores that data.
- Addressing and loops:
  - Each pass reads addresses 0 .. length-1, then wraps to 0.
  - The pass counter increments on each wrap. The last pass is the one where pass+1 == n_loops (n_loops != 0).
  - length == 2**ADDR_WIDTH wraps naturally from the all-ones address.
- Output handshake:
  - A transfer occurs in a cycle with m_valid && m_ready.
  - Once m_valid is asserted, m_data stays stable until the transfer.
  - Samples appear in strict issue order, with no loss or duplication under any m_ready pattern.
- Latency and throughput:
  - start seen at edge 0 -> ram_addr=0 in cycle 1 -> m_valid=1 with m_data=ram[0] in cycle 2.
  - With m_ready held high, one sample transfers per cycle with no bubbles, including across pass wraps.
- stop:
  - Takes effect at the edge that samples it; no further reads issue after that.
  - Samples already issued or buffered are still delivered.
  - A stop in the same cycle as start is ignored (the block is idle at that edge).
- start while busy is ignored. length and n_loops may change during playback with no effect.
- busy is high in RUN and DRAIN.

Decomposition:
- Shared package/header ram_reader_pkg: FSM state encoding (IDLE=0, RUN=1, DRAIN=2) and the buffer depth constant (2).
- One sub-module, skid_buffer_2: 2-entry FIFO with push, pop, count, head data, and fall-through when empty. The top level holds the FSM, address/pass counters and issue-credit logic.

Test Plan:
- RAM preloaded with ram[i]=i+10; length=4, n_loops=2, m_ready=1; pulse start -> stream 10,11,12,13,10,11,12,13 in consecutive cycles starting 2 cycles after start; done pulses once; busy falls with done.
- Same setup with m_ready toggling 1,0,0,1 repeating -> identical 8-sample sequence; m_data stable while m_valid && !m_ready.
- length=32 (full depth), n_loops=0; pulse stop after 40 transfers -> samples wrap 31->0 correctly; at most 2 extra samples after stop; then done; busy=0.
- length=0, pulse start -> no m_valid; done pulses 1 cycle later; busy stays 0.
- Drop rst_n for one cycle mid-stream with m_ready=0 and the buffer full -> m_valid=0 next cycle; a subsequent start replays from ram[0].
- Pulse start while busy and stop while idle -> both ignored; the sequence is unchanged.

Source files
------------

// File: rtl/ram_reader_pkg.sv
// Shared types for the RAM playback reader.
// FSM encoding and skid buffer depth.
package ram_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/ram_playback_reader_skid.sv
// Two-entry FIFO with fall-through when empty.
// Absorbs read data returning while downstream stalls.
module skid_buffer_2
  import ram_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [1:0]            count,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] mem0;
  logic [DATA_WIDTH-1:0] mem1;
  logic [1:0]            cnt;
  logic                  full;

  assign full  = (cnt == 2'(BUF_DEPTH));
  assign count = cnt;
  assign valid = (cnt != 2'd0) || push;
  assign head  = (cnt != 2'd0) ? mem0 : din;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= 2'd0;
      mem0 <= '0;
      mem1 <= '0;
    end else if (push && pop) begin
      // empty case bypasses straight through
      if (cnt == 2'd1) begin
        mem0 <= din;
      end else if (full) begin
        mem0 <= mem1;
        mem1 <= din;
      end
    end else if (push) begin
      if (cnt == 2'd0) mem0 <= din;
      else             mem1 <= din;
      cnt <= cnt + 2'd1;
    end else if (pop) begin
      mem0 <= mem1;
      cnt  <= cnt - 2'd1;
    end
  end

endmodule

// File: rtl/ram_playback_reader.sv
// Plays back RAM contents as a valid/ready stream
// for a programmed length and loop count.
module ram_playback_reader
  import ram_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int LOOP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic [LOOP_WIDTH-1:0] n_loops,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done
);

  state_t                state;
  state_t                state_nx;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LOOP_WIDTH-1:0] pass;
  logic [ADDR_WIDTH:0]   len_q;
  logic [LOOP_WIDTH-1:0] loops_q;
  logic                  in_flight;
  logic                  done_r;
  logic [1:0]            cnt;
  logic                  issue;
  logic                  at_end;
  logic                  last_pass;
  logic                  drained;
  logic                  pop;

  assign ram_addr = addr;
  assign ram_we   = 1'b0;
  assign busy     = (state != IDLE);
  assign done     = done_r;
  assign pop      = m_valid && m_ready;

  skid_buffer_2 #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_flight),
    .din   (ram_dout),
    .pop   (pop),
    .count (cnt),
    .valid (m_valid),
    .head  (m_data)
  );

  // credit: never issue more than the buffer can hold
  always_comb begin
    issue = (state == RUN) && !stop &&
            ((int'(cnt) + int'(in_flight)) < BUF_DEPTH);
    at_end = ({1'b0, addr} ==
              (len_q - {{ADDR_WIDTH{1'b0}}, 1'b1}));
    last_pass = (loops_q != '0) &&
                ((pass + LOOP_WIDTH'(1)) == loops_q);
    drained = !in_flight && (cnt == 2'd0);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start && (length != '0)) state_nx = RUN;
      end
      RUN: begin
        if (stop || (issue && at_end && last_pass))
          state_nx = DRAIN;
      end
      DRAIN: begin
        if (drained) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      pass      <= '0;
      len_q     <= '0;
      loops_q   <= '0;
      in_flight <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state     <= state_nx;
      in_flight <= issue;
      done_r    <= ((state == IDLE) && start && (length == '0)) ||
                   ((state == DRAIN) && drained);
      if ((state == IDLE) && start) begin
        addr    <= '0;
        pass    <= '0;
        len_q   <= length;
        loops_q <= n_loops;
      end else if (issue) begin
        if (at_end) begin
          addr <= '0;
          pass <= pass + LOOP_WIDTH'(1);
        end else begin
          addr <= addr + ADDR_WIDTH'(1);
        end
      end
    end
  end

endmodule
